// File: rtl/joypad_poll.sv
// Dual NES-style joypad poller with $4016/$4017 CPU shift-register interface.
// Optional build macro JOYPAD_DEBOUNCE_EN: a pad state only updates when two consecutive polls agree.
module joypad_poll #(
  parameter int unsigned POLL_DIV = 1666667,
  parameter int unsigned BIT_DIV  = 600
) (
  input  logic       clk_in,
  input  logic       nrst_in,
  input  logic       jp_data1_in,
  input  logic       jp_data2_in,
  output logic       jp_clk_out,
  output logic       jp_latch_out,
  input  logic       wr_in,
  input  logic       rd_in,
  input  logic       sel_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic [7:0] pad1_state_out,
  output logic [7:0] pad2_state_out,
  output logic       state_vld_out
);

  localparam int unsigned TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [TW-1:0] TIMER_RLD = TW'(POLL_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_DIV - 1);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    samp1_q, samp1_d, samp2_q, samp2_d;
  logic [7:0]    pad1_q, pad1_d, pad2_q, pad2_d;
  logic [7:0]    sr1_q, sr1_d, sr2_q, sr2_d;
  logic          strobe_q, strobe_d;
  logic          jp_clk_q, jp_clk_d;
  logic          latch_q, latch_d;
  logic          vld_q, vld_d;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [7:0]    prev1_q, prev1_d, prev2_q, prev2_d;
`endif
  logic          bit_end;
  logic          unused_d_in;

  assign bit_end     = (cnt_q == CNT_LAST);
  assign unused_d_in = ^d_in[7:1];

  // Poll sequencer: latch pulse, then seven pad clock pulses, one sample per bit.
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == '0) ? TIMER_RLD : timer_q - 1'b1;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    samp1_d = samp1_q;
    samp2_d = samp2_q;
    pad1_d  = pad1_q;
    pad2_d  = pad2_q;
    vld_d   = 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
    prev1_d = prev1_q;
    prev2_d = prev2_q;
`endif
    case (state_q)
      IDLE: begin
        if (timer_q == '0) begin
          state_d = LATCH;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        if (bit_end) begin
          samp1_d[0] = ~jp_data1_in;
          samp2_d[0] = ~jp_data2_in;
          cnt_d      = '0;
          bit_d      = 3'd1;
          state_d    = CLK_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLK_HI: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = CLK_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLK_LO: begin
        if (bit_end) begin
          samp1_d[bit_q] = ~jp_data1_in;
          samp2_d[bit_q] = ~jp_data2_in;
          cnt_d          = '0;
          if (bit_q == 3'd7) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = CLK_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
`ifdef JOYPAD_DEBOUNCE_EN
        if (samp1_q == prev1_q) pad1_d = samp1_q;
        if (samp2_q == prev2_q) pad2_d = samp2_q;
        prev1_d = samp1_q;
        prev2_d = samp2_q;
`else
        pad1_d = samp1_q;
        pad2_d = samp2_q;
`endif
        vld_d   = 1'b1;
        bit_d   = 3'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pad pins follow the next state so they line up with the state they belong to.
    jp_clk_d = (state_d == CLK_HI);
    latch_d  = (state_d == LATCH);
  end

  // CPU side: strobe register and the two read shift registers; a write masks a same-cycle read shift.
  always_comb begin
    strobe_d = strobe_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;
    if (wr_in && !sel_in) strobe_d = d_in[0];
    if (strobe_q) begin
      sr1_d = pad1_q;
      sr2_d = pad2_q;
    end else if (rd_in && !wr_in) begin
      if (sel_in) sr2_d = {1'b1, sr2_q[7:1]};
      else        sr1_d = {1'b1, sr1_q[7:1]};
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q  <= IDLE;
      timer_q  <= TIMER_RLD;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      samp1_q  <= 8'h00;
      samp2_q  <= 8'h00;
      pad1_q   <= 8'h00;
      pad2_q   <= 8'h00;
      sr1_q    <= 8'h00;
      sr2_q    <= 8'h00;
      strobe_q <= 1'b0;
      jp_clk_q <= 1'b0;
      latch_q  <= 1'b0;
      vld_q    <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
      prev1_q  <= 8'h00;
      prev2_q  <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      samp1_q  <= samp1_d;
      samp2_q  <= samp2_d;
      pad1_q   <= pad1_d;
      pad2_q   <= pad2_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      strobe_q <= strobe_d;
      jp_clk_q <= jp_clk_d;
      latch_q  <= latch_d;
      vld_q    <= vld_d;
`ifdef JOYPAD_DEBOUNCE_EN
      prev1_q  <= prev1_d;
      prev2_q  <= prev2_d;
`endif
    end
  end

  assign d_out          = rd_in ? {7'b0, (sel_in ? sr2_q[0] : sr1_q[0])} : 8'h00;
  assign jp_clk_out     = jp_clk_q;
  assign jp_latch_out   = latch_q;
  assign pad1_state_out = pad1_q;
  assign pad2_state_out = pad2_q;
  assign state_vld_out  = vld_q;

endmodule

// File: tb/tb_joypad_poll.sv
// Directed bench for joypad_poll (POLL_DIV=100, BIT_DIV=2) with a behavioural two-pad model.
`timescale 1ns/1ps
module tb_joypad_poll;

  localparam int unsigned POLL_DIV = 100;
  localparam int unsigned BIT_DIV  = 2;
`ifdef JOYPAD_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       nrst_in = 1'b0;
  logic       jp_data1_in, jp_data2_in;
  logic       jp_clk_out, jp_latch_out;
  logic       wr_in = 1'b0, rd_in = 1'b0, sel_in = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out, pad1_state_out, pad2_state_out;
  logic       state_vld_out;

  logic [7:0] pad1_btn = 8'h00;
  logic [7:0] pad2_btn = 8'h00;
  int pad_idx    = 0;
  int clk_pulses = 0;
  int n_tests    = 0;
  int n_fail     = 0;
  int cyc        = 0;

  joypad_poll #(.POLL_DIV(POLL_DIV), .BIT_DIV(BIT_DIV)) dut (
    .clk_in(clk_in), .nrst_in(nrst_in),
    .jp_data1_in(jp_data1_in), .jp_data2_in(jp_data2_in),
    .jp_clk_out(jp_clk_out), .jp_latch_out(jp_latch_out),
    .wr_in(wr_in), .rd_in(rd_in), .sel_in(sel_in), .d_in(d_in), .d_out(d_out),
    .pad1_state_out(pad1_state_out), .pad2_state_out(pad2_state_out),
    .state_vld_out(state_vld_out)
  );

  always #5 clk_in = ~clk_in;

  // Pad model: latch presents A, each pad clock rising edge advances one button; low = pressed.
  always @(posedge jp_latch_out or posedge jp_clk_out) begin
    if (jp_latch_out) pad_idx = 0;
    else              pad_idx = pad_idx + 1;
  end
  always @(posedge jp_clk_out) clk_pulses = clk_pulses + 1;

  assign jp_data1_in = (pad_idx < 8) ? ~pad1_btn[pad_idx[2:0]] : 1'b1;
  assign jp_data2_in = (pad_idx < 8) ? ~pad2_btn[pad_idx[2:0]] : 1'b1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
    cyc += n;
  endtask

  task automatic step_to(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic cpu_wr(input logic sel, input logic [7:0] d);
    wr_in = 1'b1; sel_in = sel; d_in = d;
    step(1);
    wr_in = 1'b0; d_in = 8'h00;
  endtask

  task automatic cpu_rd(input string tag, input logic sel, input logic exp);
    rd_in = 1'b1; sel_in = sel;
    #1 chk(tag, d_out, {7'b0, exp});
    step(1);
    rd_in = 1'b0;
  endtask

  task automatic poll_chk(input string tag, input int t, input logic [7:0] p1, input logic [7:0] p2);
    step_to(t - 1);
    chk({tag, "_vld_pre"}, {7'b0, state_vld_out}, 8'h00);
    step_to(t);
    chk({tag, "_vld"}, {7'b0, state_vld_out}, 8'h01);
    chk({tag, "_pad1"}, pad1_state_out, p1);
    chk({tag, "_pad2"}, pad2_state_out, p2);
  endtask

  initial begin
    logic [8:0] rd_seq;
    int p0;
    int nxt;

    // Reset state
    step(3);
    chk("rst_latch", {7'b0, jp_latch_out}, 8'h00);
    chk("rst_clk", {7'b0, jp_clk_out}, 8'h00);
    chk("rst_vld", {7'b0, state_vld_out}, 8'h00);
    chk("rst_pad1", pad1_state_out, 8'h00);
    chk("rst_dout", d_out, 8'h00);

    // First poll: pad 1 holds A + Start
    pad1_btn = 8'h09; pad2_btn = 8'h00;
    nrst_in = 1'b1; cyc = 0;
    step_to(99);
    chk("latch_c99", {7'b0, jp_latch_out}, 8'h00);
    step_to(100);
    chk("latch_c100", {7'b0, jp_latch_out}, 8'h01);
    step_to(101);
    chk("latch_c101", {7'b0, jp_latch_out}, 8'h01);
    p0 = clk_pulses;
    step_to(102);
    chk("latch_c102", {7'b0, jp_latch_out}, 8'h00);
    chk("jpclk_c102", {7'b0, jp_clk_out}, 8'h01);
    step_to(130);
    chk("jpclk_pulses", 8'(clk_pulses - p0), 8'd7);
    poll_chk("poll1", 131, DEB ? 8'h00 : 8'h09, 8'h00);
    step(1);
    chk("vld_c132", {7'b0, state_vld_out}, 8'h00);
    if (DEB) poll_chk("poll1b", 231, 8'h09, 8'h00);

    // Strobe 1 then 0, nine reads of $4016
    cpu_wr(1'b0, 8'h01);
    step(1);
    cpu_wr(1'b0, 8'h00);
    rd_seq = 9'b1_0000_1001;
    for (int i = 0; i < 9; i++) cpu_rd("rd4016_seq", 1'b0, rd_seq[i]);
    cpu_rd("rd4017", 1'b1, 1'b0);
    #1 chk("dout_idle", d_out, 8'h00);

    // Same-cycle write and read: write wins
    cpu_wr(1'b0, 8'h01);
    step(1);
    wr_in = 1'b1; rd_in = 1'b1; sel_in = 1'b0; d_in = 8'h00;
    #1 chk("wrrd_dout", d_out, 8'h01);
    step(1);
    wr_in = 1'b0; rd_in = 1'b0;
    cpu_rd("after_wrrd_A", 1'b0, 1'b1);
    cpu_rd("rd_B", 1'b0, 1'b0);
    cpu_rd("rd_Sel", 1'b0, 1'b0);
    wr_in = 1'b1; rd_in = 1'b1; sel_in = 1'b0; d_in = 8'h00;
    #1 chk("wrrd_start", d_out, 8'h01);
    step(1);
    wr_in = 1'b0; rd_in = 1'b0;
    cpu_rd("noshift_start", 1'b0, 1'b1);
    cpu_wr(1'b1, 8'h01);
    step(1);
    cpu_rd("sel1_wr_ignored", 1'b0, 1'b0);

    // Reset during CLK_HI of bit 4 of the next poll
    nxt = (cyc / 100 + 1) * 100;
    step_to(nxt + 14);
    chk("bit4_jpclk", {7'b0, jp_clk_out}, 8'h01);
    #1 nrst_in = 1'b0;
    #1;
    chk("midrst_clk", {7'b0, jp_clk_out}, 8'h00);
    chk("midrst_latch", {7'b0, jp_latch_out}, 8'h00);
    chk("midrst_vld", {7'b0, state_vld_out}, 8'h00);
    chk("midrst_pad1", pad1_state_out, 8'h00);
    chk("midrst_pad2", pad2_state_out, 8'h00);
    step(2);
    pad1_btn = 8'hA5; pad2_btn = 8'h3C;
    nrst_in = 1'b1; cyc = 0;
    step_to(99);
    chk("re_latch_c99", {7'b0, jp_latch_out}, 8'h00);
    step_to(100);
    chk("re_latch_c100", {7'b0, jp_latch_out}, 8'h01);

    // Consecutive polls, single-poll glitches on pad 1
    poll_chk("p2_1", 131, DEB ? 8'h00 : 8'hA5, DEB ? 8'h00 : 8'h3C);
    poll_chk("p2_2", 231, 8'hA5, 8'h3C);
    pad1_btn = 8'h00;
    poll_chk("p2_3", 331, DEB ? 8'hA5 : 8'h00, 8'h3C);
    poll_chk("p2_4", 431, 8'h00, 8'h3C);
    pad1_btn = 8'h01;
    poll_chk("p2_5", 531, DEB ? 8'h00 : 8'h01, 8'h3C);
    pad1_btn = 8'h00;
    poll_chk("p2_6", 631, 8'h00, 8'h3C);
    pad1_btn = 8'h01;
    poll_chk("p2_7", 731, DEB ? 8'h00 : 8'h01, 8'h3C);
    poll_chk("p2_8", 831, 8'h01, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/joypad_poll.md
JOYPAD_POLL -- requirements
Module: joypad_poll

Interface
REQ-001 SHALL have parameter POLL_DIV, default 1666667, meaning clk_in cycles between poll starts (60 Hz at 100 MHz).
REQ-002 SHALL have parameter BIT_DIV, default 600, meaning clk_in cycles per latch pulse and per jp_clk half-period.
REQ-003 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports jp_data1_in / jp_data2_in  input  1 each  serial pad data, low = pressed.
REQ-006 SHALL have ports jp_clk_out / jp_latch_out  output  1 each  shared pad clock and latch.
REQ-007 SHALL have ports wr_in, rd_in  input  1 each  CPU register write/read strobes, one cycle per access.
REQ-008 SHALL have port sel_in  input  1  register select, 0 = $4016 (pad 1), 1 = $4017 (pad 2).
REQ-009 SHALL have port d_in  input  8  CPU write data.
REQ-010 SHALL have port d_out  output  8  CPU read data, zero when not read (OR-bus convention).
REQ-011 SHALL have ports pad1_state_out / pad2_state_out  output  8 each  bit 1 = pressed; bits 0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-012 SHALL have port state_vld_out  output  1  one-cycle pulse when pad states update.

Function
REQ-013 SHALL run a free poll timer that counts from POLL_DIV-1 down to 0 and reloads to POLL_DIV-1.
REQ-014 SHALL use FSM states IDLE, LATCH, CLK_HI, CLK_LO and DONE.
REQ-015 SHALL move from IDLE to LATCH on the cycle after the timer reaches 0; a timer expiry outside IDLE SHALL be ignored (POLL_DIV > 15*BIT_DIV+1 is required).
REQ-016 SHALL drive jp_latch_out=1 for exactly BIT_DIV cycles in LATCH and sample inverted data (bit 0) on the last LATCH cycle.
REQ-017 For bits 1..7, SHALL spend BIT_DIV cycles in CLK_HI with jp_clk_out=1, then BIT_DIV cycles in CLK_LO with jp_clk_out=0, sampling inverted data on the last CLK_LO cycle.
REQ-018 After bit 7, SHALL spend one cycle in DONE, copy the sampled bytes to pad1/pad2_state_out, pulse state_vld_out, and return to IDLE.
REQ-019 On wr_in with sel_in=0, SHALL set the strobe register to d_in[0]; writes with sel_in=1 SHALL be ignored.
REQ-020 While strobe=1, SHALL reload both shift registers every cycle from pad1/pad2_state_out.
REQ-021 While rd_in=1, d_out SHALL be {7'b0, selected shift register bit 0}, combinationally; otherwise d_out SHALL be 8'h00.
REQ-022 On a cycle with rd_in=1 and strobe=0, SHALL shift the selected register as {1'b1, sr[7:1]}, so reads after the 8th return 1.
REQ-023 SHALL give wr_in priority over rd_in in the same cycle: the write applies and no shift occurs.
REQ-024 If state_vld_out and strobe=1 occur in the same cycle, the shift registers SHALL load the new state on the next cycle.

Reset
REQ-025 On nrst_in=0, SHALL set FSM=IDLE, timer=POLL_DIV-1, bit counter=0, strobe=0, shift registers=8'h00, and pad states=8'h00.
REQ-026 On nrst_in=0, SHALL drive jp_clk_out, jp_latch_out and state_vld_out to 0.
REQ-027 On nrst_in=0 mid-poll, SHALL abort the poll immediately, with no state update and no partial data retained.

Configuration
REQ-028 SHALL implement macro JOYPAD_DEBOUNCE_EN; when defined, a pad state updates at DONE only if the sampled byte equals the previous poll's sample for that pad.
REQ-029 When JOYPAD_DEBOUNCE_EN is defined, state_vld_out SHALL pulse at every DONE regardless of whether either pad changed.
REQ-030 When JOYPAD_DEBOUNCE_EN is undefined, each DONE SHALL update both pad states unconditionally.
REQ-031 The previous-sample registers SHALL reset to 8'h00.

Verification (POLL_DIV=100, BIT_DIV=2)
REQ-032 Release reset -> jp_latch_out rises at cycle 100 and is high for 2 cycles; 7 jp_clk pulses follow; state_vld_out pulses at cycle 131.
REQ-033 Pad 1 model returns A and Start pressed (data low on bits 0 and 3) -> pad1_state_out=8'h09, pad2_state_out=8'h00.
REQ-034 Write 1 then 0 to $4016, then 9 reads of $4016 with pad1 state 8'h09 -> d_out bit0 sequence 1,0,0,1,0,0,0,0,1.
REQ-035 Same-cycle wr_in(d_in=0) and rd_in -> strobe=0 and shift register unchanged; next read returns A.
REQ-036 Assert nrst_in during CLK_HI of bit 4 -> all outputs 0 at once; restart poll at cycle 100 after release.
REQ-037 With JOYPAD_DEBOUNCE_EN, pad1 pattern 8'h01 for one poll then 8'h00 -> pad1_state_out stays 8'h00; 8'h01 for two polls -> 8'h01.
